// File: rtl/dds_pkg.sv
// Shared definitions for the AD9910 command scheduler: command codes,
// FSM state encoding and common widths.
package dds_pkg;

  localparam int TO_W  = 20;
  localparam int GID_W = 3;

  typedef enum logic [3:0] {
    INITSETCFR2   = 4'h0,
    INITSETCFR3   = 4'h1,
    INITSETAUXDAC = 4'h2,
    RAMPSTEP      = 4'h3,
    RAMPTIMESTEP  = 4'h4,
    RAMPLIMITS    = 4'h5,
    CFR2RAMP      = 4'h6,
    STPROFILE0    = 4'h7
  } dds_cmd_e;

  typedef enum logic [2:0] {
    ST_START     = 3'd0,
    ST_INIT_LOAD = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_IDLE      = 3'd4
  } state_t;

  // Power-up step index to command code; anything past AUXDAC is AUXDAC.
  function automatic dds_cmd_e init_code(input logic [1:0] idx);
    case (idx)
      2'd0:    init_code = INITSETCFR2;
      2'd1:    init_code = INITSETCFR3;
      default: init_code = INITSETAUXDAC;
    endcase
  endfunction

endpackage

// File: rtl/dds_cmd_scheduler_rr_arbiter.sv
// Combinational round-robin pick: search starts one past the last grant
// and wraps at NREQ.
module rr_arbiter
  import dds_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]  req_valid,
  input  logic [GID_W-1:0] last_grant,
  output logic             gnt_valid,
  output logic [GID_W-1:0] gnt_idx
);

  logic [7:0] req_pad;
  logic [3:0] cand;

  assign req_pad = 8'(req_valid);

  // Walk candidates from farthest to nearest so the nearest valid one wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = {1'b0, last_grant} + 4'(k);
      if (cand >= 4'(NREQ)) begin
        cand = cand - 4'(NREQ);
      end
      if (req_pad[cand[2:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand[2:0];
      end
    end
  end

endmodule

// File: rtl/dds_cmd_scheduler.sv
// Power-up sequencer and round-robin arbiter in front of the AD9910 serial
// command engine. One command in flight at a time, each guarded by a
// completion timeout.
//
// state     | meaning
// ----------+----------------------------------------------------------
// START     | wait for the (unresettable) engine to go idle
// INIT_LOAD | load init command {init_idx, 64'h0}; doubles as idle gap
// ISSUE     | dds_ready high until the engine reports ndone=1
// WAIT_DONE | wait for ndone=0, then next init step or IDLE
// IDLE      | service pending init_req, else grant a requester
module dds_cmd_scheduler
  import dds_pkg::*;
#(
  parameter int          NREQ    = 2,
  parameter logic [19:0] TIMEOUT = 20'd1_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init_req,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [4*NREQ-1:0]    req_cmd,
  input  logic [64*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ack,
  output logic [3:0]           dds_cmd,
  output logic [63:0]          dds_data,
  output logic                 dds_ready,
  input  logic                 ndone,
  output logic [GID_W-1:0]     grant_id,
  output logic                 busy,
  output logic                 init_done,
  output logic                 timeout_err
);

  // Counter value at which the edge that would make it reach TIMEOUT aborts.
  localparam logic [TO_W-1:0] TO_LAST = TIMEOUT - 20'd1;

  state_t            state_q, state_d;
  logic [1:0]        init_idx_q, init_idx_d;
  logic              init_act_q, init_act_d;
  logic              init_pend_q, init_pend_d;
  logic [GID_W-1:0]  last_grant_q, last_grant_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [63:0]       data_q, data_d;
  logic              ready_q, ready_d;
  logic [GID_W-1:0]  gid_q, gid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              gnt_valid;
  logic [GID_W-1:0]  gnt_idx;
  logic [31:0]       cmd_pad;
  logic [511:0]      data_pad;
  logic [3:0]        cmd_sel;
  logic [63:0]       data_sel;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_valid  (req_valid),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  // Winner's command and payload, padded so the index width matches exactly.
  assign cmd_pad  = 32'(req_cmd);
  assign data_pad = 512'(req_data);
  assign cmd_sel  = cmd_pad[{gnt_idx, 2'b00} +: 4];
  assign data_sel = data_pad[{gnt_idx, 6'b000000} +: 64];

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_d      = state_q;
    init_idx_d   = init_idx_q;
    init_act_d   = init_act_q;
    init_pend_d  = init_pend_q | init_req;
    last_grant_d = last_grant_q;
    to_cnt_d     = to_cnt_q;
    ack_d        = '0;
    cmd_d        = cmd_q;
    data_d       = data_q;
    ready_d      = ready_q;
    gid_d        = gid_q;
    done_d       = done_q;
    err_d        = err_q;

    case (state_q)
      ST_START: begin
        if (!ndone) begin
          init_idx_d = 2'd0;
          init_act_d = 1'b1;
          state_d    = ST_INIT_LOAD;
        end
      end

      ST_INIT_LOAD: begin
        cmd_d    = init_code(init_idx_q);
        data_d   = 64'h0;
        ready_d  = 1'b1;
        to_cnt_d = '0;
        state_d  = ST_ISSUE;
      end

      ST_ISSUE: begin
        if (to_cnt_q == TO_LAST) begin
          ready_d    = 1'b0;
          err_d      = 1'b1;
          init_act_d = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (ndone) begin
            ready_d = 1'b0;
            state_d = ST_WAIT_DONE;
          end
        end
      end

      ST_WAIT_DONE: begin
        if (to_cnt_q == TO_LAST) begin
          ready_d    = 1'b0;
          err_d      = 1'b1;
          init_act_d = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (!ndone) begin
            if (init_act_q) begin
              if (init_idx_q == 2'd2) begin
                done_d     = 1'b1;
                init_act_d = 1'b0;
                state_d    = ST_IDLE;
              end else begin
                init_idx_d = init_idx_q + 2'd1;
                state_d    = ST_INIT_LOAD;
              end
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end

      ST_IDLE: begin
        if (init_req || init_pend_q) begin
          init_pend_d = 1'b0;
          done_d      = 1'b0;
          err_d       = 1'b0;
          init_idx_d  = 2'd0;
          init_act_d  = 1'b1;
          state_d     = ST_INIT_LOAD;
        end else if (done_q && gnt_valid) begin
          cmd_d        = cmd_sel;
          data_d       = data_sel;
          gid_d        = gnt_idx;
          last_grant_d = gnt_idx;
          for (int i = 0; i < NREQ; i++) begin
            ack_d[i] = (3'(i) == gnt_idx);
          end
          ready_d  = 1'b1;
          to_cnt_d = '0;
          state_d  = ST_ISSUE;
        end
      end

      default: begin
        state_d = ST_START;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // All state and outputs registered; reset also drops dds_ready mid-frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_START;
      init_idx_q   <= 2'd0;
      init_act_q   <= 1'b0;
      init_pend_q  <= 1'b0;
      last_grant_q <= 3'(NREQ - 1);
      to_cnt_q     <= '0;
      ack_q        <= '0;
      cmd_q        <= 4'h0;
      data_q       <= 64'h0;
      ready_q      <= 1'b0;
      gid_q        <= '0;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_idx_q   <= init_idx_d;
      init_act_q   <= init_act_d;
      init_pend_q  <= init_pend_d;
      last_grant_q <= last_grant_d;
      to_cnt_q     <= to_cnt_d;
      ack_q        <= ack_d;
      cmd_q        <= cmd_d;
      data_q       <= data_d;
      ready_q      <= ready_d;
      gid_q        <= gid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign req_ack     = ack_q;
  assign dds_cmd     = cmd_q;
  assign dds_data    = data_q;
  assign dds_ready   = ready_q;
  assign grant_id    = gid_q;
  assign busy        = busy_q;
  assign init_done   = done_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_dds_cmd_scheduler.sv
// Directed bench for dds_cmd_scheduler with a behavioural serial engine.
module tb_dds_cmd_scheduler;

  localparam int FRAME = 50;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         init_req = 1'b0;
  logic         ndone = 1'b1;
  logic [1:0]   req_valid = 2'b00;
  logic [7:0]   req_cmd = 8'h00;
  logic [127:0] req_data = 128'h0;
  logic [1:0]   req_ack;
  logic [3:0]   dds_cmd;
  logic [63:0]  dds_data;
  logic         dds_ready;
  logic [2:0]   grant_id;
  logic         busy;
  logic         init_done;
  logic         timeout_err;

  int total = 0;
  int bad = 0;

  // Engine model / monitor state
  int  eng_cnt = 0;
  bit  eng_force = 1'b1;
  bit  eng_mute = 1'b0;
  bit  rdy_prev = 1'b0;
  logic [3:0]  cap_cmd[$];
  logic [63:0] cap_data[$];
  logic [2:0]  ack_ids[$];
  logic [3:0]  ack_cmd[$];
  logic [63:0] ack_data[$];
  bit ack_early = 1'b0;
  bit ack_bad = 1'b0;
  int ack_run = 0;
  int ready_run = 0;
  int last_ready_run = 0;
  int ready_total = 0;

  localparam logic [63:0] D0 = 64'h0000_1234_0000_5678;
  localparam logic [63:0] D1 = 64'hAAAA_BBBB_CCCC_DDDD;

  dds_cmd_scheduler #(.NREQ(2), .TIMEOUT(20'd100)) dut (
    .clk         (clk),
    .rst         (rst),
    .init_req    (init_req),
    .req_valid   (req_valid),
    .req_cmd     (req_cmd),
    .req_data    (req_data),
    .req_ack     (req_ack),
    .dds_cmd     (dds_cmd),
    .dds_data    (dds_data),
    .dds_ready   (dds_ready),
    .ndone       (ndone),
    .grant_id    (grant_id),
    .busy        (busy),
    .init_done   (init_done),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Monitor plus serial engine: captures on dds_ready rise, busy FRAME cycles.
  always @(negedge clk) begin
    if (req_ack != 2'b00) begin
      if (!init_done) ack_early = 1'b1;
      if (req_ack == 2'b11) ack_bad = 1'b1;
      ack_run++;
      if (ack_run > 1) ack_bad = 1'b1;
      ack_ids.push_back(req_ack[1] ? 3'd1 : 3'd0);
      ack_cmd.push_back(dds_cmd);
      ack_data.push_back(dds_data);
    end else begin
      ack_run = 0;
    end
    if (dds_ready) begin
      ready_run++;
      ready_total++;
    end else if (ready_run > 0) begin
      last_ready_run = ready_run;
      ready_run = 0;
    end
    if (!eng_mute && !eng_force && dds_ready && !rdy_prev && eng_cnt == 0) begin
      cap_cmd.push_back(dds_cmd);
      cap_data.push_back(dds_data);
      eng_cnt = FRAME;
    end else if (eng_cnt > 0) begin
      eng_cnt--;
    end
    ndone = eng_force || (eng_cnt != 0);
    rdy_prev = dds_ready;
  end

  task automatic clear_logs();
    cap_cmd.delete();
    cap_data.delete();
    ack_ids.delete();
    ack_cmd.delete();
    ack_data.delete();
    ack_early = 1'b0;
    ack_bad = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] seq;
    logic [63:0] dor;
    #1 rst = 1'b1;
    #1;
    total++; if (dds_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", dds_ready); end
    total++; if (req_ack !== 2'b00) begin bad++; $display("FAIL rst_ack got=%b exp=00", req_ack); end
    total++; if (dds_cmd !== 4'h0) begin bad++; $display("FAIL rst_cmd got=%h exp=0", dds_cmd); end
    total++; if (dds_data !== 64'h0) begin bad++; $display("FAIL rst_data got=%h exp=0", dds_data); end
    total++; if (grant_id !== 3'd0) begin bad++; $display("FAIL rst_gid got=%0d exp=0", grant_id); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy got=%b exp=1", busy); end
    total++; if (init_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", init_done); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", timeout_err); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    // Engine still reports busy: must stay in START.
    repeat (20) @(posedge clk);
    #1;
    total++; if (ready_total !== 0) begin bad++; $display("FAIL start_hold_ready got=%0d exp=0", ready_total); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL start_hold_busy got=%b exp=1", busy); end
    clear_logs();
    req_cmd[7:4] = 4'h3;
    req_data[127:64] = D1;
    req_valid = 2'b10;
    eng_force = 1'b0;
    for (int i = 0; i < 400 && !init_done; i++) begin @(posedge clk); #1; end
    total++; if (init_done !== 1'b1) begin bad++; $display("FAIL init_wait got=%b exp=1", init_done); end
    seq = (cap_cmd.size() >= 3) ? {cap_cmd[0], cap_cmd[1], cap_cmd[2]} : 12'hfff;
    total++; if (cap_cmd.size() !== 3) begin bad++; $display("FAIL init_count got=%0d exp=3", cap_cmd.size()); end
    total++; if (seq !== 12'h012) begin bad++; $display("FAIL init_seq got=%h exp=012", seq); end
    dor = 64'h0;
    foreach (cap_data[i]) dor = dor | cap_data[i];
    total++; if (dor !== 64'h0) begin bad++; $display("FAIL init_data got=%h exp=0", dor); end
    total++; if (ndone !== 1'b0) begin bad++; $display("FAIL init_ndone got=%b exp=0", ndone); end
    for (int i = 0; i < 20 && ack_ids.size() == 0; i++) begin @(posedge clk); #1; end
    req_valid = 2'b00;
    total++; if (ack_early !== 1'b0) begin bad++; $display("FAIL ack_before_init got=%b exp=0", ack_early); end
    total++; if (ack_ids.size() !== 1) begin bad++; $display("FAIL first_ack_count got=%0d exp=1", ack_ids.size()); end
    else begin
      total++; if ({ack_ids[0], ack_cmd[0], ack_data[0]} !== {3'd1, 4'h3, D1}) begin
        bad++; $display("FAIL first_ack got=%0d/%h/%h exp=1/3/%h", ack_ids[0], ack_cmd[0], ack_data[0], D1);
      end
    end
    total++; if (grant_id !== 3'd1) begin bad++; $display("FAIL first_gid got=%0d exp=1", grant_id); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] ids;
    logic [15:0] cseq;
    for (int i = 0; i < 200 && busy; i++) begin @(posedge clk); #1; end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", busy); end
    clear_logs();
    req_cmd = {4'h3, 4'h7};
    req_data = {D1, D0};
    req_valid = 2'b11;
    for (int i = 0; i < 600 && ack_ids.size() < 4; i++) begin @(posedge clk); #1; end
    req_valid = 2'b00;
    total++; if (ack_ids.size() !== 4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", ack_ids.size()); end
    else begin
      ids = {ack_ids[0][2:0], ack_ids[1][2:0], ack_ids[2][2:0], ack_ids[3][2:0]};
      total++; if (ids !== 12'b000_001_000_001) begin bad++; $display("FAIL b2b_order got=%b exp=000001000001", ids); end
      for (int i = 0; i < 4; i++) begin
        total++;
        if ({ack_cmd[i], ack_data[i]} !== ((ack_ids[i] == 3'd1) ? {4'h3, D1} : {4'h7, D0})) begin
          bad++; $display("FAIL b2b_payload[%0d] got=%h/%h id=%0d", i, ack_cmd[i], ack_data[i], ack_ids[i]);
        end
      end
    end
    total++; if (ack_bad !== 1'b0) begin bad++; $display("FAIL b2b_ack_pulse got=%b exp=0", ack_bad); end
    for (int i = 0; i < 200 && busy; i++) begin @(posedge clk); #1; end
    total++; if (last_ready_run !== 1) begin bad++; $display("FAIL b2b_ready_len got=%0d exp=1", last_ready_run); end
    cseq = (cap_cmd.size() >= 4) ? {cap_cmd[0], cap_cmd[1], cap_cmd[2], cap_cmd[3]} : 16'hffff;
    total++; if (cseq !== 16'h7373) begin bad++; $display("FAIL b2b_engine got=%h exp=7373", cseq); end
  endtask

  task automatic test_init_priority();
    logic [11:0] seq;
    logic [15:0] seq2;
    for (int i = 0; i < 200 && busy; i++) begin @(posedge clk); #1; end
    clear_logs();
    init_req = 1'b1;
    req_valid = 2'b10;
    @(posedge clk); #1;
    init_req = 1'b0;
    @(posedge clk); #1;
    total++; if (init_done !== 1'b0) begin bad++; $display("FAIL prio_done_clr got=%b exp=0", init_done); end
    for (int i = 0; i < 400 && ack_ids.size() == 0; i++) begin @(posedge clk); #1; end
    total++; if (ack_ids.size() !== 1) begin bad++; $display("FAIL prio_ack_count got=%0d exp=1", ack_ids.size()); end
    else begin
      total++; if (ack_ids[0] !== 3'd1) begin bad++; $display("FAIL prio_ack_id got=%0d exp=1", ack_ids[0]); end
    end
    total++; if (ack_early !== 1'b0) begin bad++; $display("FAIL prio_ack_early got=%b exp=0", ack_early); end
    seq = (cap_cmd.size() >= 3) ? {cap_cmd[0], cap_cmd[1], cap_cmd[2]} : 12'hfff;
    total++; if (seq !== 12'h012) begin bad++; $display("FAIL prio_init_seq got=%h exp=012", seq); end
    // init_req while the requester's command is in flight stays pending.
    req_valid = 2'b00;
    init_req = 1'b1;
    @(posedge clk); #1;
    init_req = 1'b0;
    for (int i = 0; i < 200 && init_done; i++) begin @(posedge clk); #1; end
    for (int i = 0; i < 400 && !init_done; i++) begin @(posedge clk); #1; end
    total++; if (init_done !== 1'b1) begin bad++; $display("FAIL pend_init_done got=%b exp=1", init_done); end
    seq2 = (cap_cmd.size() == 7) ? {cap_cmd[3], cap_cmd[4], cap_cmd[5], cap_cmd[6]} : 16'hffff;
    total++; if (seq2 !== 16'h3012) begin bad++; $display("FAIL pend_seq got=%h exp=3012 n=%0d", seq2, cap_cmd.size()); end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 200 && busy; i++) begin @(posedge clk); #1; end
    clear_logs();
    eng_mute = 1'b1;
    req_valid = 2'b01;
    for (int i = 0; i < 20 && ack_ids.size() == 0; i++) begin @(posedge clk); #1; end
    req_valid = 2'b00;
    for (int i = 0; i < 300 && !timeout_err; i++) begin @(posedge clk); #1; end
    repeat (2) @(posedge clk);
    #1;
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_err got=%b exp=1", timeout_err); end
    total++; if (last_ready_run !== 100) begin bad++; $display("FAIL to_ready_len got=%0d exp=100", last_ready_run); end
    total++; if (dds_ready !== 1'b0) begin bad++; $display("FAIL to_ready_low got=%b exp=0", dds_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL to_idle got=%b exp=0", busy); end
    eng_mute = 1'b0;
    init_req = 1'b1;
    @(posedge clk); #1;
    init_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_err_clr got=%b exp=0", timeout_err); end
    for (int i = 0; i < 400 && !init_done; i++) begin @(posedge clk); #1; end
    total++; if (init_done !== 1'b1) begin bad++; $display("FAIL to_reinit got=%b exp=1", init_done); end
  endtask

  task automatic test_rst_midframe();
    logic [11:0] seq;
    for (int i = 0; i < 200 && busy; i++) begin @(posedge clk); #1; end
    clear_logs();
    req_valid = 2'b01;
    for (int i = 0; i < 20 && ack_ids.size() == 0; i++) begin @(posedge clk); #1; end
    req_valid = 2'b00;
    for (int i = 0; i < 20 && !(ndone && !dds_ready); i++) begin @(posedge clk); #1; end
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if ({dds_ready, busy, init_done, dds_cmd, grant_id} !== {1'b0, 1'b1, 1'b0, 4'h0, 3'd0}) begin
      bad++; $display("FAIL rst_wait got=rdy%b busy%b done%b cmd%h gid%0d", dds_ready, busy, init_done, dds_cmd, grant_id);
    end
    repeat (2) @(posedge clk);
    #1;
    clear_logs();
    rst = 1'b0;
    for (int i = 0; i < 400 && !init_done; i++) begin @(posedge clk); #1; end
    seq = (cap_cmd.size() >= 3) ? {cap_cmd[0], cap_cmd[1], cap_cmd[2]} : 12'hfff;
    total++; if (seq !== 12'h012) begin bad++; $display("FAIL rst_reinit_seq got=%h exp=012", seq); end
    // Reset while dds_ready is high must drop it immediately.
    eng_mute = 1'b1;
    req_valid = 2'b01;
    for (int i = 0; i < 20 && !dds_ready; i++) begin @(posedge clk); #1; end
    req_valid = 2'b00;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (dds_ready !== 1'b0) begin bad++; $display("FAIL rst_issue_ready got=%b exp=0", dds_ready); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    eng_mute = 1'b0;
    for (int i = 0; i < 400 && !init_done; i++) begin @(posedge clk); #1; end
    total++; if (init_done !== 1'b1) begin bad++; $display("FAIL rst_issue_reinit got=%b exp=1", init_done); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_init_priority();
    test_timeout();
    test_rst_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dds_cmd_scheduler.md
# dds_cmd_scheduler

Sequencer and arbiter in front of the AD9910 serial command engine. It runs the power-up CFR2/CFR3/AUX-DAC initialisation and then shares the single `dds_cmd`/`dds_data`/`dds_ready`/`ndone` port between `NREQ` requesters, for example the pulse sequencer and the host interface. Arbitration is round-robin. Exactly one command is in flight at a time, and the block watches every transaction with a completion timeout.

## Interface
- `NREQ`, default 2: number of requesters (2..8).
- `TIMEOUT`, default 20'd1_000_000: `clk` cycles allowed per transaction before abort.
- `clk`  in  1  system clock; every register in this block is clocked on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `init_req`  in  1  one-cycle pulse that re-runs the init sequence; also clears `timeout_err`.
- `req_valid`  in  NREQ  per-requester command request; held until the matching `req_ack`.
- `req_cmd`  in  4*NREQ  command code for requester i, in bits [4i+3:4i].
- `req_data`  in  64*NREQ  payload for requester i, in bits [64i+63:64i].
- `req_ack`  out  NREQ  one-cycle pulse: the command has been captured and the request is consumed.
- `dds_cmd`  out  4  to the serial engine.
- `dds_data`  out  64  to the serial engine.
- `dds_ready`  out  1  to the serial engine; the engine captures on the rising edge of this signal.
- `ndone`  in  1  from the serial engine; 1 = transaction pending, 0 = engine idle.
- `grant_id`  out  3  index of the requester currently or last granted.
- `busy`  out  1  high in every state except IDLE.
- `init_done`  out  1  high once the init sequence has completed without timeout.
- `timeout_err`  out  1  sticky flag: a transaction exceeded `TIMEOUT`.

## Operation
- FSM states: START, INIT_LOAD, ISSUE, WAIT_DONE, IDLE.
- START:
  - Entered on reset release.
  - Stays here until `ndone`=0, because the engine has no reset and may still be mid-frame.
  - Then goes to INIT_LOAD with `init_idx`=0.
- INIT_LOAD:
  - Loads the command register with {`init_idx`, 64'h0}. The codes are 4'h0 (CFR2), 4'h1 (CFR3), 4'h2 (AUXDAC).
  - Goes to ISSUE.
  - After the transaction for index 2 completes, sets `init_done`=1 and goes to IDLE.
- IDLE:
  - Priority order: a pending `init_req` first, then the round-robin grant among asserted `req_valid`.
  - Init path: clears `init_done` and `timeout_err`, then goes to INIT_LOAD with `init_idx`=0.
  - Request path:
    - Registers the winner's cmd/data into `dds_cmd`/`dds_data`.
    - Sets `grant_id`.
    - Pulses `req_ack[winner]` for one cycle.
    - Goes to ISSUE.
  - Requests are not serviced while `init_done`=0.
- ISSUE: `dds_ready`=1 until `ndone`=1 is sampled, then goes to WAIT_DONE with `dds_ready`=0.
- WAIT_DONE: stays until `ndone`=0 is sampled. Next state is INIT_LOAD if init is in progress, otherwise IDLE.
- Round-robin rule:
  - The search starts at `last_grant`+1 modulo `NREQ`.
  - `last_grant` resets to `NREQ`-1, so requester 0 wins first.
  - `last_grant` updates only when a grant is made.
- Timeout:
  - A 20-bit counter clears on entry to ISSUE and increments in ISSUE and WAIT_DONE.
  - When it reaches `TIMEOUT`: `dds_ready`=0, `timeout_err`=1, and the FSM goes to IDLE.
  - A timeout during init aborts init; `init_done` stays 0 until a successful `init_req`.
- `init_req` received while not in IDLE is latched as pending and serviced at the next IDLE.
- `dds_cmd`/`dds_data` stay stable from the ISSUE entry until the next load.

## Timing
- Reset values:
  - `dds_ready`=0, `req_ack`=0, `dds_cmd`=0, `dds_data`=0, `grant_id`=0.
  - `busy`=1, `init_done`=0, `timeout_err`=0.
  - FSM=START, `init_idx`=0, `last_grant`=`NREQ`-1, init pending=0.
- Assertion of `rst` forces all of the above immediately, including `dds_ready`=0 in the middle of a transaction. Any half-sent frame is recovered by START.
- Grant latency:
  - `req_valid` sampled in IDLE at edge t.
  - At t, registered: `req_ack`, `dds_ready`, `dds_cmd`/`dds_data`.
  - All of these are visible in cycle t+1.
- `req_ack` lasts exactly one cycle. `req_valid` still high 2 cycles after the ack counts as a new request.
- `dds_ready` is high for at least 1 cycle and drops the cycle after `ndone`=1 is sampled.
- At least one IDLE cycle separates consecutive commands, including init commands (INIT_LOAD takes that slot).
- Every output is registered.

## Structure
- Shared package `dds_pkg` holds:
  - Command codes: INITSETCFR2=4'h0, INITSETCFR3=4'h1, INITSETAUXDAC=4'h2, RAMPSTEP=4'h3, RAMPTIMESTEP=4'h4, RAMPLIMITS=4'h5, CFR2RAMP=4'h6, STPROFILE0=4'h7.
  - The FSM state encoding.
- Sub-module `rr_arbiter`:
  - Combinational round-robin pick from `req_valid` and `last_grant`.
  - Outputs `gnt_valid` and `gnt_idx`.

## Test plan
- Reset with an engine model that needs 50 cycles per frame → commands 0, 1, 2 are issued in order, each with data 0. `init_done` rises after the third `ndone` fall, and no `req_ack` is given before it.
- `ndone` held at 1 during reset release → FSM stays in START; init begins only after `ndone`=0.
- Both requesters hold `req_valid` continuously (req0 cmd 4'h7 data 64'h0000_1234_0000_5678, req1 cmd 4'h3) → grants alternate 0, 1, 0, 1; each `req_ack` lasts one cycle; `dds_data` matches the granted requester exactly.
- `init_req` and `req_valid[1]` asserted in the same IDLE cycle → the init sequence runs first; req1 is acked after `init_done` returns to 1.
- Engine model never raises `ndone`, with `TIMEOUT`=100 → `dds_ready` is high for exactly 100 cycles, then 0; `timeout_err`=1; a following `init_req` clears it and init completes.
- `rst` asserted in WAIT_DONE → `dds_ready`=0 and `busy`=1 asynchronously; after release the init sequence restarts from command 4'h0.
